// File: rtl/loader_pkg.sv
// Shared definitions for the program loader and the core: FSM states,
// instruction-memory geometry and instruction field positions.
package loader_pkg;

  localparam int IMEM_DEPTH = 16;
  localparam int INSTR_W    = 12;
  localparam int IMEM_AW    = 4;

  // Upper nibble of a HI byte must be clear
  localparam logic [7:0] HI_RSVD_MASK = 8'hF0;

  // Instruction field positions, shared with the core decoder
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 4;
  localparam int RS1_MSB = 3;
  localparam int RS1_LSB = 2;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-wide valid/ready stream from the host link into the loader.
interface program_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/program_loader.sv
// Receives a framed program over the host byte stream, writes it into the
// instruction memory and holds the core in reset until a good checksum.
module program_loader
  import loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  program_loader_if.slave    host,
  input  logic               restart,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);

  loader_state_t      state_reg;
  logic [IMEM_AW-1:0] words_left_reg;
  logic [IMEM_AW-1:0] addr_cnt_reg;
  logic [7:0]         xor_reg;
  logic [7:0]         lo_reg;
  logic               in_ready_reg;
  logic               imem_we_reg;
  logic [IMEM_AW-1:0] imem_addr_reg;
  logic [INSTR_W-1:0] imem_wdata_reg;
  logic               cpu_hold_reg;
  logic               done_reg;
  logic               error_reg;

  logic accept;
  assign accept = host.in_valid & in_ready_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      words_left_reg <= '0;
      addr_cnt_reg   <= '0;
      xor_reg        <= '0;
      lo_reg         <= '0;
      in_ready_reg   <= 1'b1;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= '0;
      cpu_hold_reg   <= 1'b1;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      imem_we_reg <= 1'b0;
      if (restart) begin
        // Restart wins over a byte presented on the same edge
        state_reg    <= IDLE;
        in_ready_reg <= 1'b1;
        cpu_hold_reg <= 1'b1;
        done_reg     <= 1'b0;
        error_reg    <= 1'b0;
      end else if (accept) begin
        unique case (state_reg)
          IDLE: begin
            words_left_reg <= host.in_data[IMEM_AW-1:0];
            addr_cnt_reg   <= '0;
            xor_reg        <= host.in_data;
            state_reg      <= LO;
          end
          LO: begin
            lo_reg    <= host.in_data;
            xor_reg   <= xor_reg ^ host.in_data;
            state_reg <= HI;
          end
          HI: begin
            if ((host.in_data & HI_RSVD_MASK) != 8'h00) begin
              state_reg    <= ERR;
              error_reg    <= 1'b1;
              in_ready_reg <= 1'b0;
            end else begin
              imem_we_reg    <= 1'b1;
              imem_addr_reg  <= addr_cnt_reg;
              imem_wdata_reg <= {host.in_data[3:0], lo_reg};
              xor_reg        <= xor_reg ^ host.in_data;
              addr_cnt_reg   <= addr_cnt_reg + 1'b1;
              if (words_left_reg == '0) begin
                state_reg <= CSUM;
              end else begin
                words_left_reg <= words_left_reg - 1'b1;
                state_reg      <= LO;
              end
            end
          end
          CSUM: begin
            in_ready_reg <= 1'b0;
            if (host.in_data == xor_reg) begin
              state_reg    <= DONE;
              done_reg     <= 1'b1;
              cpu_hold_reg <= 1'b0;
            end else begin
              state_reg <= ERR;
              error_reg <= 1'b1;
            end
          end
          default: begin
            state_reg <= state_reg;
          end
        endcase
      end
    end
  end

  assign host.in_ready = in_ready_reg;
  assign imem_we       = imem_we_reg;
  assign imem_addr     = imem_addr_reg;
  assign imem_wdata    = imem_wdata_reg;
  assign cpu_hold      = cpu_hold_reg;
  assign done          = done_reg;
  assign error         = error_reg;

endmodule
